// File: rtl/ult_pkg.sv
// Shared types and 12 MHz default timing for the ultrasonic ranging sequencer.
package ult_pkg;

  localparam int unsigned TRIG_CYCLES_DEF    = 120;
  localparam int unsigned CM_CYCLES_DEF      = 696;
  localparam int unsigned ECHO_WAIT_MAX_DEF  = 360000;
  localparam int unsigned MAX_CM_DEF         = 400;
  localparam int unsigned HOLDOFF_CYCLES_DEF = 720000;
  localparam int unsigned AUTO_PERIOD_DEF    = 12000000;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } ult_state_e;

  function automatic int unsigned max3(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ult_echo_sync.sv
// Echo pin synchroniser with registered rise/fall pulses.
module ult_echo_sync (
  input  logic clk,
  input  logic rstn,
  input  logic echo_i,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;
  logic rise_q, fall_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= echo_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
      fall_q <= ~s2_q & s3_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ult_range_ctrl.sv
// Ultrasonic ranging sequencer: trigger, echo timing, cm conversion,
// result strobe with timeout/range flags and an auto-repeat launcher.
module ult_range_ctrl
  import ult_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = TRIG_CYCLES_DEF,
  parameter int unsigned CM_CYCLES      = CM_CYCLES_DEF,
  parameter int unsigned ECHO_WAIT_MAX  = ECHO_WAIT_MAX_DEF,
  parameter int unsigned MAX_CM         = MAX_CM_DEF,
  parameter int unsigned HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF,
  parameter int unsigned AUTO_PERIOD    = AUTO_PERIOD_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       auto_en,
  input  logic       echo,
  output logic       trig,
  output logic       busy,
  output logic [8:0] dist_cm,
  output logic       dist_valid,
  output logic       err_timeout,
  output logic       err_range
);

  localparam int CNT_W =
    $clog2(max3(TRIG_CYCLES, ECHO_WAIT_MAX, HOLDOFF_CYCLES));
  localparam int SUB_W  = $clog2(CM_CYCLES);
  localparam int CM_W   = $clog2(MAX_CM + 1) + 1;
  localparam int AUTO_W = $clog2(AUTO_PERIOD);

  ult_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [CM_W-1:0]   cm_q, cm_d, cm_nx;
  logic [AUTO_W-1:0] tmr_q, tmr_d;
  logic              pend_q, pend_d;
  logic              trig_q, trig_d;
  logic [8:0]        dist_q, dist_d;
  logic              valid_q, valid_d;
  logic              eto_q, eto_d;
  logic              erg_q, erg_d;
  logic              rise, fall;
  logic              launch, wrap, cm_wrap, cm_over;

  ult_echo_sync u_sync (
    .clk   (clk),
    .rstn  (rstn),
    .echo_i(echo),
    .rise_o(rise),
    .fall_o(fall)
  );

  always_comb begin
    launch = (state_q == IDLE) && (start || pend_q);
    wrap   = auto_en && (tmr_q == AUTO_W'(AUTO_PERIOD - 1));
    tmr_d  = (!auto_en || wrap) ? '0 : tmr_q + AUTO_W'(1);
    pend_d = auto_en && (wrap || (pend_q && !launch));
  end

  // A wrap on the fall cycle still counts, so cm = floor(width / CM_CYCLES).
  always_comb begin
    cm_wrap = (sub_q == SUB_W'(CM_CYCLES - 1));
    cm_nx   = cm_wrap ? cm_q + CM_W'(1) : cm_q;
    cm_over = (cm_nx > CM_W'(MAX_CM));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    cm_d    = cm_q;
    trig_d  = 1'b0;
    dist_d  = dist_q;
    eto_d   = eto_q;
    erg_d   = erg_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (launch) begin
          state_d = TRIG;
          cnt_d   = '0;
          trig_d  = 1'b1;
        end
      end
      TRIG: begin
        if (cnt_q == CNT_W'(TRIG_CYCLES - 1)) begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
        end else begin
          trig_d = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      WAIT_RISE: begin
        if (rise) begin
          state_d = MEASURE;
          sub_d   = '0;
          cm_d    = '0;
        end else if (cnt_q == CNT_W'(ECHO_WAIT_MAX - 1)) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
          valid_d = 1'b1;
          dist_d  = '0;
          eto_d   = 1'b1;
          erg_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MEASURE: begin
        if (fall || cm_over) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
          valid_d = 1'b1;
          eto_d   = 1'b0;
          erg_d   = cm_over;
          dist_d  = cm_over ? 9'(MAX_CM) : 9'(cm_nx);
        end else begin
          sub_d = cm_wrap ? '0 : sub_q + SUB_W'(1);
          cm_d  = cm_nx;
        end
      end
      HOLDOFF: begin
        if (cnt_q == CNT_W'(HOLDOFF_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sub_q   <= '0;
      cm_q    <= '0;
      tmr_q   <= '0;
      pend_q  <= 1'b0;
      trig_q  <= 1'b0;
      dist_q  <= '0;
      valid_q <= 1'b0;
      eto_q   <= 1'b0;
      erg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      cm_q    <= cm_d;
      tmr_q   <= tmr_d;
      pend_q  <= pend_d;
      trig_q  <= trig_d;
      dist_q  <= dist_d;
      valid_q <= valid_d;
      eto_q   <= eto_d;
      erg_q   <= erg_d;
    end
  end

  assign trig        = trig_q;
  assign busy        = (state_q != IDLE);
  assign dist_cm     = dist_q;
  assign dist_valid  = valid_q;
  assign err_timeout = eto_q;
  assign err_range   = erg_q;

endmodule

// File: tb/tb_ult_range_ctrl.sv
// Randomized self-checking bench for ult_range_ctrl with scaled timing.
module tb_ult_range_ctrl;

  localparam int TRIG = 5;
  localparam int CM   = 8;
  localparam int EWM  = 60;
  localparam int MAXC = 20;
  localparam int HOLD = 30;
  localparam int AUTO = 400;
  // pin change is sampled on the next edge, then 3 clk to a decision
  localparam int SYNC_LAT = 4;

  typedef struct {
    int cyc;
    int d;
    int to;
    int rg;
  } vrec_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       auto_en = 1'b0;
  logic       echo = 1'b0;
  logic       trig, busy, dist_valid, err_timeout, err_range;
  logic [8:0] dist_cm;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_rise = 0;
  int n_valid = 0;
  int last_idle = 0;
  int trun = 0;
  int rises[$];
  vrec_t vq[$];
  logic trig_p = 1'b0;
  logic valid_p = 1'b0;
  logic busy_p = 1'b0;

  ult_range_ctrl #(
    .TRIG_CYCLES   (TRIG),
    .CM_CYCLES     (CM),
    .ECHO_WAIT_MAX (EWM),
    .MAX_CM        (MAXC),
    .HOLDOFF_CYCLES(HOLD),
    .AUTO_PERIOD   (AUTO)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .auto_en    (auto_en),
    .echo       (echo),
    .trig       (trig),
    .busy       (busy),
    .dist_cm    (dist_cm),
    .dist_valid (dist_valid),
    .err_timeout(err_timeout),
    .err_range  (err_range)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      trig_p  = 1'b0;
      valid_p = 1'b0;
      busy_p  = 1'b0;
      trun    = 0;
    end else begin
      if (trig && !trig_p) begin
        n_rise++;
        rises.push_back(cyc);
        trun = 0;
      end
      if (trig) trun++;
      if (!trig && trig_p) check("trig_width", trun, TRIG);
      if (dist_valid) begin
        check("valid_gap", int'(valid_p), 0);
        n_valid++;
        vq.push_back('{cyc, int'(dist_cm), int'(err_timeout),
                       int'(err_range)});
      end
      if (!busy && busy_p) last_idle = cyc;
      trig_p  = trig;
      valid_p = dist_valid;
      busy_p  = busy;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < HOLD + 400) begin
      step();
      n++;
    end
    check("reach_idle", int'(busy), 0);
    repeat (3) step();
  endtask

  // w == 0 means no echo pulse at all; pre holds echo high from TRIG on
  task automatic run_meas(int dly, int w, bit spam, bit pre);
    int base, c_tf, c_r, c_f, n, e_d, e_to, e_rg, e_cyc;
    vrec_t v;
    base = n_rise;
    c_r = 0;
    c_f = 0;
    pulse_start();
    if (pre) echo = 1'b1;
    n = 0;
    while (trig && n < 1000) begin
      start = spam;
      step();
      n++;
    end
    start = 1'b0;
    c_tf = cyc;
    if (w > 0) begin
      repeat (dly) step();
      echo = 1'b1;
      c_r = cyc;
      for (int i = 0; i < w; i++) begin
        start = spam && (i == w / 2);
        step();
      end
      start = 1'b0;
      echo = 1'b0;
      c_f = cyc;
    end
    if (w == 0) begin
      e_d = 0; e_to = 1; e_rg = 0; e_cyc = c_tf + EWM;
    end else if (w / CM > MAXC) begin
      e_d = MAXC; e_to = 0; e_rg = 1;
      e_cyc = c_r + SYNC_LAT + (MAXC + 1) * CM;
    end else begin
      e_d = w / CM; e_to = 0; e_rg = 0; e_cyc = c_f + SYNC_LAT;
    end
    n = 0;
    while (vq.size() == 0 && n < EWM + 300) begin
      step();
      n++;
    end
    check("result_seen", int'(vq.size() != 0), 1);
    if (vq.size() != 0) begin
      v = vq.pop_front();
      check("dist_cm", v.d, e_d);
      check("err_timeout", v.to, e_to);
      check("err_range", v.rg, e_rg);
      check("result_cycle", v.cyc, e_cyc);
      if (spam && busy) pulse_start();
      echo = 1'b0;
      wait_idle();
      check("holdoff_len", last_idle - v.cyc, HOLD);
    end else begin
      echo = 1'b0;
      wait_idle();
    end
    check("launches", n_rise - base, 1);
  endtask

  task automatic run_reset();
    int nv, n;
    pulse_start();
    n = 0;
    while (trig && n < 1000) begin
      step();
      n++;
    end
    echo = 1'b1;
    repeat (3 * CM) step();
    nv = n_valid;
    #2 rstn = 1'b0;
    #1;
    check("rst_trig", int'(trig), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(dist_valid), 0);
    repeat (4) @(posedge clk);
    #1;
    echo = 1'b0;
    rstn = 1'b1;
    repeat (10) step();
    check("rst_no_result", n_valid - nv, 0);
    check("rst_dist", int'(dist_cm), 0);
    check("rst_idle", int'(busy), 0);
  endtask

  task automatic run_auto();
    int base, c_en, n, r, w2, l, idle, e_rise;
    vrec_t v;
    base = rises.size();
    c_en = cyc;
    auto_en = 1'b1;
    n = 0;
    while (rises.size() < base + 3 && n < 4 * AUTO) begin
      step();
      n++;
    end
    check("auto_rises", rises.size() - base, 3);
    if (rises.size() >= base + 3) begin
      check("auto_first", rises[base] - c_en, AUTO + 1);
      check("auto_period1", rises[base + 1] - rises[base], AUTO);
      check("auto_period2", rises[base + 2] - rises[base + 1], AUTO);
      // place a start so the next wrap lands mid-holdoff
      r = rises[base + 2];
      w2 = r - 1 + AUTO;
      l = w2 - (TRIG + EWM + HOLD / 2);
      while (cyc < l - 1) step();
      pulse_start();
      idle = l + TRIG + EWM + HOLD;
      e_rise = (w2 < idle) ? idle + 1 : w2 + 1;
      n = 0;
      while (rises.size() < base + 5 && n < 2 * AUTO) begin
        step();
        n++;
      end
      check("auto_hold_rises", rises.size() - base, 5);
      if (rises.size() >= base + 5) begin
        check("start_launch", rises[base + 3], l);
        check("hold_wrap_launch", rises[base + 4], e_rise);
      end
    end
    auto_en = 1'b0;
    wait_idle();
    check("auto_results", vq.size(), 5);
    while (vq.size() != 0) begin
      v = vq.pop_front();
      check("auto_timeout", v.to, 1);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_trig", int'(trig), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(dist_valid), 0);
    check("reset_dist", int'(dist_cm), 0);
    check("reset_err", int'({err_timeout, err_range}), 0);
    rstn = 1'b1;
    repeat (3) step();

    run_meas(7, CM * 10, 1'b1, 1'b0);
    run_meas(3, CM * 7 + CM - 1, 1'b0, 1'b0);
    run_meas(0, CM - 1, 1'b0, 1'b0);
    run_meas(0, 1, 1'b0, 1'b0);
    run_meas(12, MAXC * CM + CM - 1, 1'b0, 1'b0);
    run_meas(5, (MAXC + 1) * CM, 1'b1, 1'b0);
    run_meas(2, (MAXC + 1) * CM + 40, 1'b0, 1'b0);
    run_meas(0, 0, 1'b0, 1'b0);
    run_meas(0, 0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      run_meas(int'($urandom_range(0, 40)),
               int'($urandom_range(1, (MAXC + 3) * CM)), 1'b0, 1'b0);
    end

    run_reset();
    run_auto();

    check("one_result_per_launch", n_valid, n_rise - 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
